// File: rtl/riscv_aes_wb_unit.sv
// riscv_aes_wb_unit -- AES result writeback stage.
// Latches one NUM_WORDS x DATA_WIDTH AES result and a word-aligned destination
// base address, then stores the words to data memory as sequential
// single-outstanding bus writes and pulses done_o when the last write is
// acknowledged.
// Optional build macro: RISCV_AES_WB_BYTESWAP_EN -- byte-reverse each word on
// the write-data bus so the block lands in memory in FIPS-197 byte order.
module riscv_aes_wb_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            result_valid_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] result_i,
    input  logic [DATA_WIDTH-1:0]           wb_addr_i,
    output logic                            result_ready_o,
    output logic                            data_req_o,
    input  logic                            data_gnt_i,
    input  logic                            data_rvalid_i,
    output logic [DATA_WIDTH-1:0]           data_addr_o,
    output logic [DATA_WIDTH-1:0]           data_wdata_o,
    output logic                            data_we_o,
    output logic [3:0]                      data_be_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        idx_next;
    logic [DATA_WIDTH-1:0]   base_reg;
    logic [DATA_WIDTH-1:0]   buf_reg [NUM_WORDS];
    logic                    capture;
    logic                    req_active;
    logic [DATA_WIDTH-1:0]   word_sel;
    logic [DATA_WIDTH-1:0]   word_out;

    // A new result is taken only while idle; upstream holds it otherwise.
    assign capture = (state_reg == IDLE) && result_valid_i;

    // State and word index; reset aborts any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Base address is forced word-aligned: the low two bits are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg <= '0;
        end else if (capture) begin
            base_reg <= wb_addr_i & ~DATA_WIDTH'(3);
        end
    end

    // Result buffer, loaded in one shot on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_reg[i] <= result_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: one request, wait for its response, then advance.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (result_valid_i) begin
                    state_next = REQ;
                    idx_next   = '0;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // Responses are only meaningful here; elsewhere they are dropped.
                if (data_rvalid_i) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign word_sel = buf_reg[idx_reg];

`ifdef RISCV_AES_WB_BYTESWAP_EN
    // Byte k of the bus word comes from byte (NUM_BYTES-1-k) of the result word.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_swap
        assign word_out[gi*8 +: 8] = word_sel[(NUM_BYTES-1-gi)*8 +: 8];
    end
`else
    assign word_out = word_sel;
`endif

    // Outputs decode straight from state so a reset drops the request at once.
    assign req_active     = (state_reg == REQ);
    assign result_ready_o = (state_reg == IDLE);
    assign busy_o         = (state_reg != IDLE);
    assign done_o         = (state_reg == DONE);
    assign data_req_o     = req_active;
    assign data_we_o      = req_active;
    assign data_be_o      = req_active ? 4'hF : 4'h0;
    assign data_addr_o    = req_active ? (base_reg + (DATA_WIDTH'(idx_reg) << 2)) : '0;
    assign data_wdata_o   = req_active ? word_out : '0;

endmodule

// File: tb/tb_riscv_aes_wb_unit.sv
// tb_riscv_aes_wb_unit -- randomized self-checking bench for riscv_aes_wb_unit.
// The reference model is a list of expected (address, data) writes derived
// from the result and destination address, plus a cycle-count formula for
// done_o given the grant and response delays the bench chooses per word.
// Honours RISCV_AES_WB_BYTESWAP_EN in the model when defined.
module tb_riscv_aes_wb_unit;

    localparam int DW = 32;
    localparam int NW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            result_valid_i = 1'b0;
    logic [NW*DW-1:0] result_i = '0;
    logic [DW-1:0]   wb_addr_i = '0;
    logic            result_ready_o;
    logic            data_req_o;
    logic            data_gnt_i = 1'b0;
    logic            data_rvalid_i = 1'b0;
    logic [DW-1:0]   data_addr_o;
    logic [DW-1:0]   data_wdata_o;
    logic            data_we_o;
    logic [3:0]      data_be_o;
    logic            busy_o;
    logic            done_o;

    int unsigned cyc = 0;
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int gd_arr[NW];
    int rd_arr[NW];

    riscv_aes_wb_unit #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .result_valid_i (result_valid_i),
        .result_i       (result_i),
        .wb_addr_i      (wb_addr_i),
        .result_ready_o (result_ready_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Memory image of one result word as the bus should carry it.
    function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef RISCV_AES_WB_BYTESWAP_EN
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
`else
        return w;
`endif
    endfunction

    task automatic check_idle_bus(input string tag);
        check_val({tag, "_req"},   32'(data_req_o),   32'd0);
        check_val({tag, "_addr"},  data_addr_o,       32'd0);
        check_val({tag, "_wdata"}, data_wdata_o,      32'd0);
        check_val({tag, "_we"},    32'(data_we_o),    32'd0);
        check_val({tag, "_be"},    32'(data_be_o),    32'd0);
    endtask

    // Store one block; called and returning at a negedge with the DUT idle.
    // gd_arr/rd_arr give per-word grant and response delays. With hold_next the
    // next result is presented (valid high) throughout the store. abort_word>=0
    // applies reset right after that word is granted.
    task automatic run_block(input logic [127:0] res, input logic [31:0] addr,
                             input bit hold_next, input logic [127:0] nres,
                             input logic [31:0] naddr, input int abort_word);
        int unsigned t_cap;
        int unsigned exp_len;
        int n;
        logic [31:0] base, ea, ed;
        base = addr & 32'hFFFF_FFFC;
        result_valid_i = 1'b1;
        result_i = res;
        wb_addr_i = addr;
        n = 0;
        while (!result_ready_o && n < 50) begin @(negedge clk); n++; end
        check_val("ready_at_capture", 32'(result_ready_o), 32'd1);
        t_cap = cyc;
        @(negedge clk);
        if (hold_next) begin
            result_i = nres;
            wb_addr_i = naddr;
        end else begin
            result_valid_i = 1'b0;
        end
        exp_len = 1;
        for (int k = 0; k < NW; k++) begin
            ea = base + 32'(4 * k);
            ed = model_word(res[32*k +: 32]);
            n = 0;
            while (!data_req_o && n < 50) begin @(negedge clk); n++; end
            check_val("req", 32'(data_req_o), 32'd1);
            check_val("addr", data_addr_o, ea);
            check_val("wdata", data_wdata_o, ed);
            check_val("we", 32'(data_we_o), 32'd1);
            check_val("be", 32'(data_be_o), 32'hF);
            check_val("busy", 32'(busy_o), 32'd1);
            if (hold_next) check_val("bp_ready", 32'(result_ready_o), 32'd0);
            for (int s = 0; s < gd_arr[k]; s++) begin
                @(negedge clk);
                check_val("stall_req", 32'(data_req_o), 32'd1);
                check_val("stall_addr", data_addr_o, ea);
                check_val("stall_wdata", data_wdata_o, ed);
            end
            data_gnt_i = 1'b1;
            @(negedge clk);
            data_gnt_i = 1'b0;
            check_idle_bus("wait_rsp");
            if (k == abort_word) begin
                rst_n = 1'b0;
                #1;
                check_idle_bus("abort");
                check_val("abort_ready", 32'(result_ready_o), 32'd1);
                check_val("abort_busy", 32'(busy_o), 32'd0);
                check_val("abort_done", 32'(done_o), 32'd0);
                result_valid_i = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                data_rvalid_i = 1'b1;   // late response to the aborted write
                @(negedge clk);
                data_rvalid_i = 1'b0;
                check_val("late_rsp_ready", 32'(result_ready_o), 32'd1);
                check_idle_bus("late_rsp");
                return;
            end
            for (int s = 0; s < rd_arr[k]; s++) begin
                @(negedge clk);
                check_val("rsp_wait_req", 32'(data_req_o), 32'd0);
            end
            data_rvalid_i = 1'b1;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            exp_len += 32'(gd_arr[k] + rd_arr[k] + 2);
        end
        check_val("done", 32'(done_o), 32'd1);
        check_val("done_cycle", cyc - t_cap, exp_len);
        @(negedge clk);
        check_val("done_pulse", 32'(done_o), 32'd0);
        check_val("ready_after", 32'(result_ready_o), 32'd1);
    endtask

    task automatic set_delays(input int g0, input int g1, input int g2, input int g3,
                              input int r0, input int r1, input int r2, input int r3);
        gd_arr = '{g0, g1, g2, g3};
        rd_arr = '{r0, r1, r2, r3};
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [31:0]  aa, ab;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_ready", 32'(result_ready_o), 32'd1);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_idle_bus("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Stray response right after reset must be ignored.
        data_rvalid_i = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        check_val("stray_ready", 32'(result_ready_o), 32'd1);
        check_idle_bus("stray");

        // Basic zero-wait store.
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        run_block({32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000},
                  32'h0000_1000, 1'b0, '0, '0, -1);
        // Grant stall of three cycles on word 2.
        set_delays(0, 0, 3, 0, 0, 0, 0, 0);
        run_block({32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000},
                  32'h0000_1000, 1'b0, '0, '0, -1);
        // Unaligned address wrapping past 2^32.
        set_delays(0, 1, 0, 0, 1, 0, 0, 2);
        run_block({32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA},
                  32'hFFFF_FFFB, 1'b0, '0, '0, -1);
        // Byte-order check word.
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        run_block({32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304},
                  32'h0000_2000, 1'b0, '0, '0, -1);
        // Back-pressure: second result waits for the first store to finish.
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        aa = $urandom;
        ab = $urandom;
        set_delays(1, 0, 2, 0, 0, 1, 0, 0);
        run_block(ra, aa, 1'b1, rb, ab, -1);
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        run_block(rb, ab, 1'b0, '0, '0, -1);
        // Reset after word 1 is granted, then a fresh store from word 0.
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 32'h0000_3000, 1'b0, '0, '0, 1);
        run_block({32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777},
                  32'h0000_4000, 1'b0, '0, '0, -1);
        // Randomized blocks with random bus delays.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < NW; k++) begin
                gd_arr[k] = int'($urandom_range(0, 3));
                rd_arr[k] = int'($urandom_range(0, 2));
            end
            run_block({$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0, '0, '0, -1);
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
